// File: rtl/rand_note_seq_if.sv
// Sequencer control and note outputs, shared by the sequencer and its stimulus driver.
// The signal names match the original port names.
interface rand_note_seq_if;
   logic       en;
   logic [4:0] rand_in;
   logic [2:0] note;
   logic       note_on;
   logic       note_start;
   logic       beat_tick;

   modport master (
      output en, rand_in,
      input  note, note_on, note_start, beat_tick
   );

   modport slave (
      input  en, rand_in,
      output note, note_on, note_start, beat_tick
   );
endinterface

// File: rtl/rand_note_seq.sv
// Random melody sequencer: samples an LFSR word on beat boundaries and turns it into
// pitch/duration notes, suppressing immediate pitch repeats.
module rand_note_seq #(
   parameter int unsigned BEAT_DIV = 12_500_000,
   parameter int unsigned DIV_W    = 24
) (
   input logic          clk,
   input logic          rst,
   rand_note_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       remain_q, remain_d;
   logic [2:0]       prev_q, prev_d;
   logic [2:0]       note_q, note_d;
   logic             on_q, on_d;
   logic             start_q, start_d;
   logic             tick_q, tick_d;

   logic             wrap;
   logic             sample;
   logic [2:0]       pitch;
   logic [2:0]       pitch_adj;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         remain_q <= '0;
         prev_q   <= '0;
         note_q   <= '0;
         on_q     <= 1'b0;
         start_q  <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         remain_q <= remain_d;
         prev_q   <= prev_d;
         note_q   <= note_d;
         on_q     <= on_d;
         start_q  <= start_d;
         tick_q   <= tick_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      remain_d  = remain_q;
      prev_d    = prev_q;
      note_d    = note_q;
      on_d      = on_q;
      start_d   = 1'b0;
      tick_d    = 1'b0;
      sample    = 1'b0;
      wrap      = (div_q == DIV_LAST);
      pitch     = bus.rand_in[2:0];
      pitch_adj = pitch;

      if (!bus.en) begin
         // Disabling discards any partial beat and forgets the last pitch.
         state_d  = IDLE;
         div_d    = '0;
         remain_d = '0;
         prev_d   = '0;
         note_d   = '0;
         on_d     = 1'b0;
      end else begin
         div_d  = wrap ? '0 : div_q + 1'b1;
         tick_d = wrap;

         case (state_q)
            IDLE: state_d = WAIT;
            WAIT: begin
               if (wrap) begin
                  sample  = 1'b1;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (wrap) begin
                  if (remain_q != 2'd0) remain_d = remain_q - 2'd1;
                  else                  sample   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (sample) begin
            remain_d = bus.rand_in[4:3];
            if (pitch == 3'd0) begin
               note_d = '0;
               on_d   = 1'b0;
            end else begin
               // Step a repeated pitch up by one, skipping the rest code on wrap.
               if (pitch == prev_q) pitch_adj = (pitch == 3'd7) ? 3'd1 : pitch + 3'd1;
               note_d  = pitch_adj;
               on_d    = 1'b1;
               start_d = 1'b1;
               prev_d  = pitch_adj;
            end
         end
      end
   end

   assign bus.note       = note_q;
   assign bus.note_on    = on_q;
   assign bus.note_start = start_q;
   assign bus.beat_tick  = tick_q;

endmodule

// File: tb/tb_rand_note_seq.sv
// Directed bench for rand_note_seq with a scoreboard of expected per-beat outputs.
module tb_rand_note_seq;
   localparam int unsigned BD = 4;

   logic clk = 1'b0;
   logic rst;

   rand_note_seq_if bus ();

   rand_note_seq #(.BEAT_DIV(BD), .DIV_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [4:0]  sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int unsigned n);
      n = 0;
      do begin
         step();
         n++;
         if (!bus.beat_tick) check("start_off_beat", 32'(bus.note_start), 32'd0);
      end while (!bus.beat_tick && n < 20);
   endtask

   task automatic expect_tick(input logic [2:0] nt, input logic on, input logic st);
      sb.push_back({nt, on, st});
   endtask

   task automatic drain();
      int unsigned n;
      logic [4:0]  e;
      while (sb.size() != 0) begin
         wait_tick(n);
         e = sb.pop_front();
         check("tick_gap",   32'(n),              32'(BD));
         check("note",       32'(bus.note),       32'(e[4:2]));
         check("note_on",    32'(bus.note_on),    32'(e[1]));
         check("note_start", 32'(bus.note_start), 32'(e[0]));
         // Words presented between sampling ticks must be ignored.
         bus.rand_in = 5'b10110;
      end
   endtask

   task automatic check_silent(input string tag);
      check({tag, "_note"},  32'(bus.note),       32'd0);
      check({tag, "_on"},    32'(bus.note_on),    32'd0);
      check({tag, "_start"}, 32'(bus.note_start), 32'd0);
      check({tag, "_tick"},  32'(bus.beat_tick),  32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.en      = 1'b0;
      bus.rand_in = '0;
      repeat (3) step();
      check_silent("reset");
      rst = 1'b0;
      repeat (2) step();
      check_silent("idle");

      // First note: pitch 3, two beats
      bus.rand_in = 5'b01011;
      bus.en      = 1'b1;
      expect_tick(3'd3, 1'b1, 1'b1);
      expect_tick(3'd3, 1'b1, 1'b0);
      drain();

      // Repeat of 3 bumps to 4
      bus.rand_in = 5'b00011;
      expect_tick(3'd4, 1'b1, 1'b1);
      drain();

      // 7 then 7 again wraps to 1
      bus.rand_in = 5'b00111;
      expect_tick(3'd7, 1'b1, 1'b1);
      drain();
      bus.rand_in = 5'b00111;
      expect_tick(3'd1, 1'b1, 1'b1);
      drain();

      // Rest keeps previous pitch (1), so a following 1 becomes 2
      bus.rand_in = 5'b00000;
      expect_tick(3'd0, 1'b0, 1'b0);
      drain();
      bus.rand_in = 5'b00001;
      expect_tick(3'd2, 1'b1, 1'b1);
      drain();

      // Four-beat note
      bus.rand_in = 5'b11101;
      expect_tick(3'd5, 1'b1, 1'b1);
      expect_tick(3'd5, 1'b1, 1'b0);
      expect_tick(3'd5, 1'b1, 1'b0);
      expect_tick(3'd5, 1'b1, 1'b0);
      drain();

      // Disable mid-note
      bus.rand_in = 5'b01010;
      expect_tick(3'd2, 1'b1, 1'b1);
      drain();
      step();
      bus.en = 1'b0;
      step();
      check_silent("disable");
      repeat (2) step();
      check_silent("disabled");

      // Re-enable: prev pitch cleared, so 2 stays 2; full beat before first note
      bus.rand_in = 5'b01010;
      bus.en      = 1'b1;
      expect_tick(3'd2, 1'b1, 1'b1);
      expect_tick(3'd2, 1'b1, 1'b0);
      drain();

      // Async reset between edges while note=5
      bus.rand_in = 5'b01101;
      expect_tick(3'd5, 1'b1, 1'b1);
      drain();
      #3;
      rst = 1'b1;
      #1;
      check("async_note", 32'(bus.note),    32'd0);
      check("async_on",   32'(bus.note_on), 32'd0);
      bus.en = 1'b0;
      #2;
      rst = 1'b0;
      repeat (2) step();
      check_silent("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", checks, errors + 1);
      $fatal(1, "watchdog");
   end
endmodule
